uart_receive: RTL and testbench
===============================

Name: uart_receive

Overview:
UART receive path, the downstream counterpart of the UART transmit stage. It consumes the serial line and recovers frames of start bit, 8 data bits LSB-first, optional parity and one stop bit, using 16x oversampling. Recovered bytes land in a one-entry holding register read by the BusController. Status flags report receive-not-empty, parity error, framing error and overrun.

Parameters:
OVERSAMPLE, 16, baud ticks per bit; must be a power of two and ≥8.
SYNC_STAGES, 2, flip-flops in the rx_i metastability synchroniser.

Ports:
clk_i  input  1  system clock, one clock domain
rst_i  input  1  asynchronous, active-high reset
rx_i  input  1  serial line, idles high
uart_cr_i  input  6  control register: bit4 = PCE (parity enable), bit5 = PS (1 = odd, 0 = even); other bits ignored
baud16_tick_i  input  1  one-cycle pulse at OVERSAMPLE x baud, from the BaudGenerator
baudgenerator_en_o  output  1  requests ticks from the BaudGenerator while a frame is active
read_i  input  1  BusController read strobe for the holding register
data_o  output  8  holding register
rxne_o  output  1  holding register full
rc_o  output  1  one-cycle receive-complete pulse
pe_o  output  1  parity error of the held byte
fe_o  output  1  framing error of the held byte
ovr_o  output  1  overrun: a byte was lost
busy_o  output  1  frame in progress

Behaviour:
- Reset values: all outputs 0, the synchroniser chain 1, state IDLE.
- rx_s is rx_i after SYNC_STAGES flip-flops. All sampling uses rx_s.
- tick_cnt is log2(OVERSAMPLE) bits wide and increments only on baud16_tick_i.
- bit_cnt is 3 bits; shift_reg is 8 bits.
- State IDLE:
  - When rx_s == 0: go to START, set tick_cnt = 0, set baudgenerator_en_o = 1 and busy_o = 1.
  - Latch PCE and PS into internal copies. Changes to uart_cr_i mid-frame have no effect.
- State START:
  - On the tick where tick_cnt == OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - If rx_s == 0: go to DATA with tick_cnt = 0 and bit_cnt = 0.
  - If rx_s == 1 (glitch): go to IDLE, clear busy and the enable. No flags change.
- State DATA:
  - On the tick where tick_cnt == OVERSAMPLE-1 (mid-bit), shift rx_s into shift_reg[7] with a right shift, and increment bit_cnt.
  - After the 8th bit: go to PARITY if PCE is latched, otherwise to STOP.
- State PARITY:
  - Sample at mid-bit.
  - perr = (^shift_reg ^ parity_bit) != PS. Even parity expects the XOR of all 9 bits to be 0; odd expects 1.
  - perr is forced to 0 when PCE == 0.
- State STOP:
  - Sample at mid-bit. ferr = (rx_s == 0).
  - Perform the completion sequence, then return to IDLE in the same cycle with baudgenerator_en_o = 0 and busy_o = 0.
  - Returning at mid stop bit allows back-to-back frames.
- Completion sequence:
  - rc_o pulses for exactly one clk_i cycle.
  - If rxne_o == 0, or read_i is asserted in the same cycle: load data_o = shift_reg, pe_o = perr, fe_o = ferr, rxne_o = 1.
  - Otherwise (overrun): discard the new byte and set ovr_o = 1. data_o, pe_o and fe_o keep the old byte's values.
- read_i without a completion in the same cycle: clears rxne_o, pe_o, fe_o and ovr_o on the next edge. data_o holds its value.
- read_i while rxne_o == 0: clears ovr_o only.
- Latency: rc_o is asserted in the clk_i cycle after the mid-stop-bit tick.
- A tick and rx_s falling in the same IDLE cycle: that tick is not counted.
- Reset asserted mid-frame: immediate return to the reset state. A partial frame is lost and no flag is set.
- Default or illegal state: go to IDLE.

Test Plan:
1. PCE=0: send 0x55 at 16x ticks -> rc_o pulses once; data_o=0x55, rxne_o=1, pe_o=0, fe_o=0; busy_o low after the frame.
2. PCE=1, PS=0: send 0xA3 with parity bit 0 -> data_o=0xA3, pe_o=0. Repeat with parity bit 1 -> pe_o=1. Then PS=1 with parity bit 1 -> pe_o=0.
3. Glitch: rx_i low for 4 ticks, then high -> no rc_o, rxne_o stays 0, busy_o returns to 0 by tick 8.
4. Framing error: send 0x3C with the stop bit held 0 -> data_o=0x3C, fe_o=1.
5. Overrun: send 0x11 then 0x22 without read_i -> data_o=0x11, ovr_o=1. A subsequent read_i clears rxne_o and ovr_o. read_i coincident with the 0x22 completion instead -> data_o=0x22, ovr_o=0.
6. Reset mid-frame: assert rst_i during bit 3 of 0xFF -> all outputs 0 with no clock edge needed. The next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_receive.sv
// UART receiver: 16x-oversampled start/8-data/optional-parity/stop framing,
// one-entry holding register with rxne/pe/fe/ovr status and rc pulse.
module uart_receive #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   input  logic [5:0] uart_cr_i,
   input  logic       baud16_tick_i,
   output logic       baudgenerator_en_o,
   input  logic       read_i,
   output logic [7:0] data_o,
   output logic       rxne_o,
   output logic       rc_o,
   output logic       pe_o,
   output logic       fe_o,
   output logic       ovr_o,
   output logic       busy_o
);

   localparam int TW = $clog2(OVERSAMPLE);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   pce_q, pce_d, ps_q, ps_d, par_q, par_d;
   logic [7:0]             data_q, data_d;
   logic                   rxne_q, rxne_d, rc_q, rc_d;
   logic                   pe_q, pe_d, fe_q, fe_d, ovr_q, ovr_d;

   logic rx_s, mid_start, mid_bit, complete, ferr, perr;

   assign rx_s      = sync_q[SYNC_STAGES-1];
   assign mid_start = baud16_tick_i && (tick_cnt_q == TW'(OVERSAMPLE/2 - 1));
   assign mid_bit   = baud16_tick_i && (tick_cnt_q == TW'(OVERSAMPLE - 1));
   // Parity is only meaningful when it was enabled at frame start.
   assign perr      = pce_q & ((^shift_q ^ par_q) != ps_q);

   // Frame sequencer plus holding-register / status update.
   always_comb begin
      state_d    = state_q;
      sync_d     = {sync_q[SYNC_STAGES-2:0], rx_i};
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pce_d      = pce_q;
      ps_d       = ps_q;
      par_d      = par_q;
      data_d     = data_q;
      rxne_d     = rxne_q;
      rc_d       = 1'b0;
      pe_d       = pe_q;
      fe_d       = fe_q;
      ovr_d      = ovr_q;
      complete   = 1'b0;
      ferr       = 1'b0;

      if (baud16_tick_i && state_q != IDLE)
         tick_cnt_d = tick_cnt_q + TW'(1);

      case (state_q)
         IDLE: begin
            // Ticks in IDLE are never counted; the frame clock starts at 0.
            tick_cnt_d = '0;
            pce_d      = uart_cr_i[4];
            ps_d       = uart_cr_i[5];
            if (!rx_s) state_d = START;
         end
         START: begin
            if (mid_start) begin
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (mid_bit) begin
               shift_d   = {rx_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = pce_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (mid_bit) begin
               par_d   = rx_s;
               state_d = STOP;
            end
         end
         STOP: begin
            // Leave at mid stop bit so a following start edge is not missed.
            if (mid_bit) begin
               complete = 1'b1;
               ferr     = !rx_s;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (complete) begin
         rc_d = 1'b1;
         if (!rxne_q || read_i) begin
            data_d = shift_q;
            pe_d   = perr;
            fe_d   = ferr;
            rxne_d = 1'b1;
            if (read_i) ovr_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (read_i) begin
         ovr_d = 1'b0;
         if (rxne_q) begin
            rxne_d = 1'b0;
            pe_d   = 1'b0;
            fe_d   = 1'b0;
         end
      end
   end

   // State and datapath registers; synchroniser resets to line idle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         sync_q     <= '1;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         pce_q      <= 1'b0;
         ps_q       <= 1'b0;
         par_q      <= 1'b0;
         data_q     <= '0;
         rxne_q     <= 1'b0;
         rc_q       <= 1'b0;
         pe_q       <= 1'b0;
         fe_q       <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         pce_q      <= pce_d;
         ps_q       <= ps_d;
         par_q      <= par_d;
         data_q     <= data_d;
         rxne_q     <= rxne_d;
         rc_q       <= rc_d;
         pe_q       <= pe_d;
         fe_q       <= fe_d;
         ovr_q      <= ovr_d;
      end
   end

   assign busy_o             = (state_q != IDLE);
   assign baudgenerator_en_o = (state_q != IDLE);
   assign data_o             = data_q;
   assign rxne_o             = rxne_q;
   assign rc_o               = rc_q;
   assign pe_o               = pe_q;
   assign fe_o               = fe_q;
   assign ovr_o              = ovr_q;

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboarded bench for uart_receive: stimulus pushes expected completions,
// a monitor pops and compares on every rc_o pulse.
module tb_uart_receive;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       rx_i = 1'b1;
   logic [5:0] uart_cr_i = '0;
   logic       baud16_tick_i = 1'b0;
   logic       baudgenerator_en_o;
   logic       read_i = 1'b0;
   logic [7:0] data_o;
   logic       rxne_o, rc_o, pe_o, fe_o, ovr_o, busy_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       pe;
      logic       fe;
      logic       ovr;
   } exp_t;

   exp_t exp_q[$];

   uart_receive #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .rx_i(rx_i), .uart_cr_i(uart_cr_i),
      .baud16_tick_i(baud16_tick_i), .baudgenerator_en_o(baudgenerator_en_o),
      .read_i(read_i), .data_o(data_o), .rxne_o(rxne_o), .rc_o(rc_o),
      .pe_o(pe_o), .fe_o(fe_o), .ovr_o(ovr_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe, input logic ovr);
      exp_t e;
      e.data = d; e.pe = pe; e.fe = fe; e.ovr = ovr;
      return e;
   endfunction

   // Hold rx at b for n ticks (one tick every 4 clocks); optionally pulse read_i with tick rd.
   task automatic send_bit(input logic b, input int n, input int rd);
      rx_i = b;
      for (int i = 0; i < n; i++) begin
         repeat (3) @(negedge clk_i);
         baud16_tick_i = 1'b1;
         if (i == rd) read_i = 1'b1;
         @(negedge clk_i);
         baud16_tick_i = 1'b0;
         read_i = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic stopb, input int rd_stop, input logic [5:0] cr_mid);
      send_bit(1'b0, 16, -1);
      uart_cr_i = cr_mid;
      for (int i = 0; i < 8; i++) send_bit(d[i], 16, -1);
      if (pen) send_bit(pbit, 16, -1);
      send_bit(stopb, 8, rd_stop);   // tick index 7 is the mid-stop sample
      send_bit(1'b1, 8, -1);
      send_bit(1'b1, 16, -1);        // idle gap
   endtask

   task automatic do_read();
      @(negedge clk_i);
      read_i = 1'b1;
      @(negedge clk_i);
      read_i = 1'b0;
   endtask

   // Monitor: every rc_o pulse must match the oldest expected completion.
   initial forever begin
      @(negedge clk_i);
      if (rc_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rc", 32'(rc_o), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_data", 32'(data_o), 32'(e.data));
            chk("sb_pe",   32'(pe_o),   32'(e.pe));
            chk("sb_fe",   32'(fe_o),   32'(e.fe));
            chk("sb_ovr",  32'(ovr_o),  32'(e.ovr));
            chk("sb_rxne", 32'(rxne_o), 32'd1);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_outs", {baudgenerator_en_o, data_o, rxne_o, rc_o, pe_o, fe_o, ovr_o, busy_o}, 32'd0);
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);

      // 1: plain 8N1
      exp_q.push_back(mk(8'h55, 0, 0, 0));
      send_frame(8'h55, 0, 0, 1, -1, 6'h00);
      chk("t1_busy", 32'(busy_o), 32'd0);
      chk("t1_en", 32'(baudgenerator_en_o), 32'd0);
      do_read();
      chk("t1_rxne_rd", 32'(rxne_o), 32'd0);
      chk("t1_data_hold", 32'(data_o), 32'h55);

      // 2: parity even/odd
      uart_cr_i = 6'h10;
      exp_q.push_back(mk(8'hA3, 0, 0, 0));
      send_frame(8'hA3, 1, 0, 1, -1, 6'h10);
      do_read();
      exp_q.push_back(mk(8'hA3, 1, 0, 0));
      send_frame(8'hA3, 1, 1, 1, -1, 6'h10);
      do_read();
      chk("t2_pe_rd", 32'(pe_o), 32'd0);
      uart_cr_i = 6'h30;
      exp_q.push_back(mk(8'hA3, 0, 0, 0));
      send_frame(8'hA3, 1, 1, 1, -1, 6'h30);
      do_read();
      // control changed mid-frame must be ignored
      uart_cr_i = 6'h10;
      exp_q.push_back(mk(8'hA3, 0, 0, 0));
      send_frame(8'hA3, 1, 0, 1, -1, 6'h00);
      do_read();

      // 3: start glitch
      send_bit(1'b0, 4, -1);
      chk("t3_busy_mid", 32'(busy_o), 32'd1);
      send_bit(1'b1, 4, -1);
      chk("t3_busy_end", 32'(busy_o), 32'd0);
      chk("t3_rxne", 32'(rxne_o), 32'd0);
      send_bit(1'b1, 16, -1);

      // 4: framing error
      uart_cr_i = 6'h00;
      exp_q.push_back(mk(8'h3C, 0, 1, 0));
      send_frame(8'h3C, 0, 0, 0, -1, 6'h00);
      chk("t4_busy", 32'(busy_o), 32'd0);
      do_read();
      chk("t4_fe_rd", 32'(fe_o), 32'd0);

      // 5: overrun, then read clears; then read coincident with completion
      exp_q.push_back(mk(8'h11, 0, 0, 0));
      send_frame(8'h11, 0, 0, 1, -1, 6'h00);
      exp_q.push_back(mk(8'h11, 0, 0, 1));
      send_frame(8'h22, 0, 0, 1, -1, 6'h00);
      do_read();
      chk("t5_rxne_rd", 32'(rxne_o), 32'd0);
      chk("t5_ovr_rd", 32'(ovr_o), 32'd0);
      exp_q.push_back(mk(8'h11, 0, 0, 0));
      send_frame(8'h11, 0, 0, 1, -1, 6'h00);
      exp_q.push_back(mk(8'h22, 0, 0, 0));
      send_frame(8'h22, 0, 0, 1, 7, 6'h00);
      chk("t5_data_rdco", 32'(data_o), 32'h22);

      // 6: async reset during bit 3 of 0xFF (holding register still full)
      send_bit(1'b0, 16, -1);
      send_bit(1'b1, 48, -1);
      send_bit(1'b1, 5, -1);
      chk("t6_busy_pre", 32'(busy_o), 32'd1);
      #2 rst_i = 1'b1;
      #1 chk("t6_rst_outs", {baudgenerator_en_o, data_o, rxne_o, rc_o, pe_o, fe_o, ovr_o, busy_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      send_bit(1'b1, 32, -1);
      exp_q.push_back(mk(8'h81, 0, 0, 0));
      send_frame(8'h81, 0, 0, 1, -1, 6'h00);
      chk("t6_busy_end", 32'(busy_o), 32'd0);

      repeat (4) @(negedge clk_i);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
